// File: rtl/window_sr_pkg.sv
// window_sr_pkg: shared types and index helpers for the sliding-window shift register.
package window_sr_pkg;

    typedef enum logic [1:0] {EMPTY, FILL, FULL} fill_state_t;

    function automatic int fill_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int lane_lo(input int bits, input int n, input int c);
        return c * n * bits;
    endfunction

    function automatic int tap_lo(input int bits, input int n, input int c, input int i);
        return (c * n + i) * bits;
    endfunction

endpackage

// File: rtl/window_shift_reg_if.sv
// window_shift_reg_if: sample-in / window-out handshake bundle for window_shift_reg.
interface window_shift_reg_if
    import window_sr_pkg::*;
#(
    parameter int BITS = 8,
    parameter int N    = 3,
    parameter int CH   = 1
);
    logic [BITS*CH-1:0]   in_data;
    logic                 in_valid;
    logic                 in_sof;
    logic                 in_ready;
    logic [BITS*N*CH-1:0] out_window;
    logic                 out_valid;
    logic                 out_ready;
    logic [fill_w(N)-1:0] fill_cnt;

    modport slave (
        input  in_data, in_valid, in_sof, out_ready,
        output in_ready, out_window, out_valid, fill_cnt
    );

    modport master (
        output in_data, in_valid, in_sof, out_ready,
        input  in_ready, out_window, out_valid, fill_cnt
    );
endinterface

// File: rtl/window_sr_lane.sv
// window_sr_lane: one channel's N-tap chain; tap 0 is newest.
module window_sr_lane #(
    parameter int BITS = 8,
    parameter int N    = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            shift,
    input  logic            clr,
    input  logic            rep,
    input  logic [BITS-1:0] din,
    output logic [BITS*N-1:0] taps
);
    logic [BITS*N-1:0] nxt;

    // replicate wins over clear-and-load, which wins over a plain shift
    always_comb nxt = rep   ? {N{din}} :
                      clr   ? (BITS*N)'(din) :
                      shift ? ((taps << BITS) | (BITS*N)'(din)) : taps;

    always_ff @(posedge clk or posedge rst)
        if (rst) taps <= '0;
        else     taps <= nxt;
endmodule

// File: rtl/window_shift_reg.sv
// window_shift_reg: multi-channel sliding window with fill tracking and frame restart.
// Define WINDOW_SR_REPLICATE_EN to border-replicate the first sample of a frame into all taps.
module window_shift_reg
    import window_sr_pkg::*;
#(
    parameter int BITS = 8,
    parameter int N    = 3,
    parameter int CH   = 1
) (
    input logic               clk,
    input logic               rst,
    window_shift_reg_if.slave bus
);
    localparam int FW = fill_w(N);
    localparam logic [FW-1:0] N_CNT = FW'(N);

    logic [FW-1:0]        fill;
    logic [FW-1:0]        fill_nxt;
    logic                 valid;
    logic                 valid_nxt;
    logic                 accept;
    logic                 sof_acc;
    logic                 shift;
    logic                 clr;
    logic                 rep;
    fill_state_t          state;
    logic [BITS*N*CH-1:0] window;

    assign bus.in_ready   = !valid | bus.out_ready;
    assign accept         = bus.in_valid & bus.in_ready;
    assign sof_acc        = accept & bus.in_sof;
    assign shift          = accept & !bus.in_sof;
    assign bus.out_valid  = valid;
    assign bus.fill_cnt   = fill;
    assign bus.out_window = window;

`ifdef WINDOW_SR_REPLICATE_EN
    localparam logic [FW-1:0] SOF_CNT = N_CNT;
    assign rep = sof_acc;
    assign clr = 1'b0;
`else
    localparam logic [FW-1:0] SOF_CNT = FW'(1);
    assign rep = 1'b0;
    assign clr = sof_acc;
`endif

    for (genvar c = 0; c < CH; c++) begin : g_lane
        window_sr_lane #(.BITS(BITS), .N(N)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .shift (shift),
            .clr   (clr),
            .rep   (rep),
            .din   (bus.in_data[c*BITS +: BITS]),
            .taps  (window[lane_lo(BITS, N, c) +: BITS*N])
        );
    end

    // fill state is fully encoded by the saturating counter
    always_comb begin
        state     = fill == '0 ? EMPTY : fill == N_CNT ? FULL : FILL;
        fill_nxt  = !accept ? fill : bus.in_sof ? SOF_CNT : state == FULL ? fill : fill + 1'b1;
        valid_nxt = (accept && fill_nxt == N_CNT) ? 1'b1 : bus.out_ready ? 1'b0 : valid;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            fill  <= '0;
            valid <= 1'b0;
        end else begin
            fill  <= fill_nxt;
            valid <= valid_nxt;
        end
endmodule
